// File: rtl/execute_pipe_md.sv
// Execute stage with valid/ready handshakes, MEM/WB operand forwarding
// and an iterative RV32M multiply/divide unit (one bit per cycle).
module execute_pipe_md #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rs1,
   input  logic [ADDR_WIDTH-1:0] in_rs2,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0] in_rd1,
   input  logic [DATA_WIDTH-1:0] in_rd2,
   input  logic [DATA_WIDTH-1:0] in_imm,
   input  logic                  in_alu_src,
   input  logic [3:0]            in_alu_ctrl,
   input  logic                  in_md_en,
   input  logic [2:0]            in_md_op,
   input  logic                  fwd_mem_we,
   input  logic [ADDR_WIDTH-1:0] fwd_mem_rd,
   input  logic [DATA_WIDTH-1:0] fwd_mem_data,
   input  logic                  fwd_wb_we,
   input  logic [ADDR_WIDTH-1:0] fwd_wb_rd,
   input  logic [DATA_WIDTH-1:0] fwd_wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_eq,
   output logic [DATA_WIDTH-1:0] out_write_data,
   output logic [ADDR_WIDTH-1:0] out_rd,
   output logic                  busy
);

   localparam int DW = DATA_WIDTH;
   localparam int SW = $clog2(DATA_WIDTH);

   typedef enum logic {IDLE, MD_BUSY} state_t;

   state_t          state, state_nx;
   logic [DW-1:0]   fwd1, fwd2, op2, alu_res;
   logic            accept, alu_acc, md_acc, md_done;
   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [DW-1:0]   a_mag, b_mag;

   logic [DW-1:0]   md_hi, md_lo, md_b;
   logic [2:0]      md_op;
   logic            md_neg, md_sa, md_bzero;
   logic            md_eq;
   logic [DW-1:0]   md_wd;
   logic [ADDR_WIDTH-1:0] md_rd;
   logic [SW-1:0]   cnt;

   logic [DW:0]     mul_sum, div_sh;
   logic [DW-1:0]   div_tr;
   logic            div_ge;
   logic [DW-1:0]   hi_nx, lo_nx;
   logic [2*DW-1:0] prod, prod_f;
   logic [DW-1:0]   quo_f, rem_f, md_res;

   // Operand forwarding: x0 reads zero, EX/MEM beats MEM/WB beats regfile
   always_comb begin
      fwd1 = in_rd1;
      if (in_rs1 == '0)                             fwd1 = '0;
      else if (fwd_mem_we && fwd_mem_rd == in_rs1) fwd1 = fwd_mem_data;
      else if (fwd_wb_we && fwd_wb_rd == in_rs1)    fwd1 = fwd_wb_data;
      fwd2 = in_rd2;
      if (in_rs2 == '0)                             fwd2 = '0;
      else if (fwd_mem_we && fwd_mem_rd == in_rs2) fwd2 = fwd_mem_data;
      else if (fwd_wb_we && fwd_wb_rd == in_rs2)    fwd2 = fwd_wb_data;
      op2 = in_alu_src ? in_imm : fwd2;
   end

   // Single-cycle ALU
   always_comb begin
      alu_res = '0;
      case (in_alu_ctrl)
         4'd0: alu_res = fwd1 + op2;
         4'd1: alu_res = fwd1 - op2;
         4'd2: alu_res = fwd1 & op2;
         4'd3: alu_res = fwd1 | op2;
         4'd4: alu_res = fwd1 ^ op2;
         4'd5: alu_res[0] = $signed(fwd1) < $signed(op2);
         4'd6: alu_res[0] = fwd1 < op2;
         4'd7: alu_res = fwd1 << op2[SW-1:0];
         4'd8: alu_res = fwd1 >> op2[SW-1:0];
         4'd9: alu_res = DW'($signed(fwd1) >>> op2[SW-1:0]);
         default: alu_res = '0;
      endcase
   end

   // Operand signedness and magnitudes for the M-unit
   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (in_md_op)
         3'd0, 3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
         3'd2:                   a_sgn = 1'b1;
         default:                ;
      endcase
      a_neg = a_sgn & fwd1[DW-1];
      b_neg = b_sgn & fwd2[DW-1];
      a_mag = a_neg ? -fwd1 : fwd1;
      b_mag = b_neg ? -fwd2 : fwd2;
   end

   // Handshake: accept only when idle, not flushing and the out slot frees up
   always_comb begin
      in_ready = rst_n && (state == IDLE) && !flush && (!out_valid || out_ready);
      accept   = in_valid && in_ready;
      alu_acc  = accept && !in_md_en;
      md_acc   = accept && in_md_en;
      busy     = (state == MD_BUSY);
   end

   // FSM next state; flush overrides completion
   always_comb begin
      state_nx = state;
      md_done  = 1'b0;
      case (state)
         IDLE:    if (md_acc) state_nx = MD_BUSY;
         MD_BUSY: if (cnt == '0) begin
                     state_nx = IDLE;
                     md_done  = 1'b1;
                  end
         default: state_nx = IDLE;
      endcase
      if (flush) begin
         state_nx = IDLE;
         md_done  = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // One iteration step and the sign-fixed final result. The last step's
   // outcome is used combinationally so the result lands on the cnt==0 edge.
   always_comb begin
      mul_sum = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
      div_sh  = {md_hi, md_lo[DW-1]};
      div_ge  = div_sh >= {1'b0, md_b};
      div_tr  = div_sh[DW-1:0] - md_b;
      if (md_op[2]) begin
         hi_nx = div_ge ? div_tr : div_sh[DW-1:0];
         lo_nx = {md_lo[DW-2:0], div_ge};
      end else begin
         hi_nx = mul_sum[DW:1];
         lo_nx = {mul_sum[0], md_lo[DW-1:1]};
      end
      prod   = {hi_nx, lo_nx};
      prod_f = md_neg ? -prod : prod;
      quo_f  = md_bzero ? '1 : (md_neg ? -lo_nx : lo_nx);
      rem_f  = md_sa ? -hi_nx : hi_nx;
      case (md_op)
         3'd0:             md_res = prod_f[DW-1:0];
         3'd1, 3'd2, 3'd3: md_res = prod_f[2*DW-1:DW];
         3'd4, 3'd5:       md_res = quo_f;
         default:          md_res = rem_f;
      endcase
   end

   // M-unit operand/iteration registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         md_hi    <= '0;
         md_lo    <= '0;
         md_b     <= '0;
         md_op    <= '0;
         md_neg   <= 1'b0;
         md_sa    <= 1'b0;
         md_bzero <= 1'b0;
         md_eq    <= 1'b0;
         md_wd    <= '0;
         md_rd    <= '0;
      end else if (md_acc) begin
         md_hi    <= '0;
         md_lo    <= a_mag;
         md_b     <= b_mag;
         md_op    <= in_md_op;
         md_neg   <= a_neg ^ b_neg;
         md_sa    <= a_neg;
         md_bzero <= (fwd2 == '0);
         md_eq    <= (fwd1 == fwd2);
         md_wd    <= fwd2;
         md_rd    <= in_rd;
      end else if (state == MD_BUSY) begin
         md_hi <= hi_nx;
         md_lo <= lo_nx;
      end
   end

   // Iteration counter
   always_ff @(posedge clk) begin
      if (!rst_n || flush)                 cnt <= '0;
      else if (md_acc)                     cnt <= SW'(DW - 1);
      else if (state == MD_BUSY && cnt != '0) cnt <= cnt - SW'(1);
   end

   // EX/MEM output slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_result     <= '0;
         out_eq         <= 1'b0;
         out_write_data <= '0;
         out_rd         <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (alu_acc) begin
         out_valid      <= 1'b1;
         out_result     <= alu_res;
         out_eq         <= (fwd1 == fwd2);
         out_write_data <= fwd2;
         out_rd         <= in_rd;
      end else if (md_done) begin
         out_valid      <= 1'b1;
         out_result     <= md_res;
         out_eq         <= md_eq;
         out_write_data <= md_wd;
         out_rd         <= md_rd;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_execute_pipe_md.sv
// Self-checking bench for execute_pipe_md: directed cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_execute_pipe_md;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready;
   logic [AW-1:0] in_rs1, in_rs2, in_rd;
   logic [DW-1:0] in_rd1, in_rd2, in_imm;
   logic          in_alu_src;
   logic [3:0]    in_alu_ctrl;
   logic          in_md_en;
   logic [2:0]    in_md_op;
   logic          fwd_mem_we, fwd_wb_we;
   logic [AW-1:0] fwd_mem_rd, fwd_wb_rd;
   logic [DW-1:0] fwd_mem_data, fwd_wb_data;
   logic          out_valid, out_ready, out_eq, busy;
   logic [DW-1:0] out_result, out_write_data;
   logic [AW-1:0] out_rd;

   int checks   = 0;
   int failures = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   execute_pipe_md #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
      .in_alu_src(in_alu_src), .in_alu_ctrl(in_alu_ctrl),
      .in_md_en(in_md_en), .in_md_op(in_md_op),
      .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_eq(out_eq), .out_write_data(out_write_data), .out_rd(out_rd),
      .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference rules ----------------
   function automatic logic [31:0] fwd_val(input logic [AW-1:0] rs, input logic [31:0] rdat);
      if (rs == '0) return '0;
      if (fwd_mem_we && fwd_mem_rd == rs) return fwd_mem_data;
      if (fwd_wb_we && fwd_wb_rd == rs) return fwd_wb_data;
      return rdat;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (c)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6: return (a < b) ? 32'd1 : 32'd0;
         4'd7: return a << sh;
         4'd8: return a >> sh;
         4'd9: return 32'($signed(a) >>> sh);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return 32'($signed(a) / $signed(b));
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            return 32'($signed(a) % $signed(b));
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // ---------------- transaction-level model ----------------
   int            m_left = 0;
   logic          m_ov = 1'b0;
   logic [31:0]   m_res = '0, m_wd = '0, s_res = '0, s_wd = '0;
   logic          m_eq = 1'b0, s_eq = 1'b0;
   logic [AW-1:0] m_rd = '0, s_rd = '0;

   function automatic logic exp_ready();
      return rst_n && (m_left == 0) && !flush && (!m_ov || out_ready);
   endfunction

   always @(posedge clk) begin
      logic        acc;
      logic [31:0] a, b2, o2;
      acc = in_valid && exp_ready();
      a   = fwd_val(in_rs1, in_rd1);
      b2  = fwd_val(in_rs2, in_rd2);
      o2  = in_alu_src ? in_imm : b2;
      if (!rst_n) begin
         m_left = 0; m_ov = 1'b0; m_res = '0; m_eq = 1'b0; m_wd = '0; m_rd = '0;
      end else if (flush) begin
         m_left = 0; m_ov = 1'b0;
      end else if (acc && !in_md_en) begin
         m_ov = 1'b1; m_res = ref_alu(in_alu_ctrl, a, o2);
         m_eq = (a == b2); m_wd = b2; m_rd = in_rd;
      end else if (acc) begin
         m_ov = 1'b0; m_left = DW;
         s_res = ref_md(in_md_op, a, b2); s_eq = (a == b2); s_wd = b2; s_rd = in_rd;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_ov = 1'b1; m_res = s_res; m_eq = s_eq; m_wd = s_wd; m_rd = s_rd;
         end
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready", 32'(in_ready), 32'(exp_ready()));
         chk("busy", 32'(busy), 32'(m_left != 0));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         if (m_ov) begin
            chk("out_result", out_result, m_res);
            chk("out_eq", 32'(out_eq), 32'(m_eq));
            chk("out_write_data", out_write_data, m_wd);
            chk("out_rd", 32'(out_rd), 32'(m_rd));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
      in_rd1 = '0; in_rd2 = '0; in_imm = '0; in_alu_src = 1'b0; in_alu_ctrl = '0;
      in_md_en = 1'b0; in_md_op = '0; fwd_mem_we = 1'b0; fwd_mem_rd = '0;
      fwd_mem_data = '0; fwd_wb_we = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
      out_ready = 1'b1;
   endtask

   task automatic drive_op(input logic md, input logic [3:0] c, input logic [2:0] mop,
                           input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [AW-1:0] rd, input logic [31:0] d1, input logic [31:0] d2);
      in_valid = 1'b1; in_md_en = md; in_alu_ctrl = c; in_md_op = mop;
      in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd1 = d1; in_rd2 = d2;
      in_alu_src = 1'b0; in_imm = '0;
   endtask

   task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int n, viol;
      drive_op(1'b1, 4'd0, op, 5'd1, 5'd2, 5'd4, a, b);
      step();
      in_valid = 1'b0;
      n = 0; viol = 0;
      while (!out_valid && n < 40) begin
         if (!busy || in_ready) viol++;
         step();
         n++;
      end
      chk({name, "_latency"}, n + 1, DW + 1);
      chk({name, "_result"}, out_result, exp);
      chk({name, "_busy_stall"}, viol, 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'd7;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] held;
      logic        ov_seen;

      // model pins from hand-computed values
      chk("pin_div_ovf", ref_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      chk("pin_rem_ovf", ref_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
      chk("pin_mulhu", ref_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      chk("pin_sra", ref_alu(4'd9, 32'h8000_0000, 32'd4), 32'hF800_0000);

      idle();
      rst_n = 1'b0;
      step(); step();
      cmp_en = 1'b1;
      chk("reset_in_ready", 32'(in_ready), 0);
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_out_result", out_result, 0);
      rst_n = 1'b1;
      step();

      // plain ADD
      drive_op(1'b0, 4'd0, 3'd0, 5'd5, 5'd6, 5'd3, 32'd7, 32'd9);
      step();
      in_valid = 1'b0;
      chk("add_result", out_result, 32'd16);
      chk("add_eq", 32'(out_eq), 0);
      chk("add_valid", 32'(out_valid), 1);

      // forwarding: MEM wins over WB, x0 reads zero
      fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'd100;
      fwd_wb_we = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'd200;
      drive_op(1'b0, 4'd0, 3'd0, 5'd5, 5'd6, 5'd3, 32'd7, 32'd9);
      step();
      chk("fwd_mem_priority", out_result, 32'd109);
      drive_op(1'b0, 4'd0, 3'd0, 5'd0, 5'd6, 5'd3, 32'd7, 32'd9);
      step();
      in_valid = 1'b0;
      chk("fwd_x0", out_result, 32'd9);
      fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
      step();

      // M-unit corner cases
      run_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_md("divu_zero", 3'd5, 32'd12345, 32'd0, 32'hFFFF_FFFF);
      run_md("remu_zero", 3'd7, 32'd7, 32'd0, 32'd7);
      run_md("div_zero", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
      run_md("rem_zero", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
      run_md("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
      run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_md("mul", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
      run_md("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

      // back-pressure: slot holds, stage stalls, next op goes on release
      drive_op(1'b0, 4'd0, 3'd0, 5'd1, 5'd2, 5'd7, 32'd10, 32'd20);
      step();
      held = out_result;
      chk("bp_first", held, 32'd30);
      out_ready = 1'b0;
      drive_op(1'b0, 4'd0, 3'd0, 5'd1, 5'd2, 5'd8, 32'd1, 32'd2);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready_low", 32'(in_ready), 0);
         chk("bp_hold_result", out_result, held);
         chk("bp_hold_rd", 32'(out_rd), 7);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      chk("bp_second", out_result, 32'd3);
      step();

      // flush during DIVU
      drive_op(1'b1, 4'd0, 3'd5, 5'd1, 5'd2, 5'd9, 32'd1000, 32'd3);
      step();
      in_valid = 1'b0;
      ov_seen = 1'b0;
      repeat (9) begin
         ov_seen |= out_valid;
         step();
      end
      flush = 1'b1;
      drive_op(1'b0, 4'd0, 3'd0, 5'd1, 5'd2, 5'd10, 32'd4, 32'd5);
      #1;
      chk("flush_blocks_accept", 32'(in_ready), 0);
      step();
      flush = 1'b0;
      #1;
      chk("flush_idle", 32'(busy), 0);
      chk("flush_no_valid", 32'(out_valid | ov_seen), 0);
      chk("flush_ready_again", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      chk("flush_next_add", out_result, 32'd9);
      chk("flush_next_valid", 32'(out_valid), 1);

      // reset in the middle of a multiply
      drive_op(1'b1, 4'd0, 3'd0, 5'd1, 5'd2, 5'd11, 32'd3, 32'd5);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_result", out_result, 0);
      chk("midrst_rd", 32'(out_rd), 0);
      chk("midrst_ready", 32'(in_ready), 0);
      rst_n = 1'b1;
      step();

      // randomized traffic
      repeat (4000) begin
         in_valid     = ($urandom_range(0, 9) < 6);
         in_md_en     = ($urandom_range(0, 9) < 3);
         in_md_op     = 3'($urandom_range(0, 7));
         in_alu_ctrl  = 4'($urandom_range(0, 15));
         in_alu_src   = 1'($urandom_range(0, 1));
         in_rs1       = 5'($urandom_range(0, 3));
         in_rs2       = 5'($urandom_range(0, 3));
         in_rd        = 5'($urandom_range(0, 31));
         in_rd1       = pick();
         in_rd2       = pick();
         in_imm       = pick();
         fwd_mem_we   = 1'($urandom_range(0, 1));
         fwd_mem_rd   = 5'($urandom_range(0, 3));
         fwd_mem_data = pick();
         fwd_wb_we    = 1'($urandom_range(0, 1));
         fwd_wb_rd    = 5'($urandom_range(0, 3));
         fwd_wb_data  = pick();
         out_ready    = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 59) == 0);
         step();
      end

      idle();
      repeat (40) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
